// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button conditioner.
// Imported by the conditioner RTL and its bench.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int unsigned CNT_BITS_DEF   = 20;
  localparam int unsigned RPT_DELAY_DEF  = 25000000;
  localparam int unsigned RPT_PERIOD_DEF = 10000000;

  function automatic int unsigned hold_bits(
    input int unsigned a,
    input int unsigned b
  );
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key pin plus conditioned level/strobe bundle.
// The master drives the pin, the slave returns clean signals.
interface key_conditioner_if;
  logic noisy_ni;
  logic pressed_o;
  logic press_o;
  logic release_o;
  logic repeat_o;

  modport master (
    output noisy_ni,
    input  pressed_o,
    input  press_o,
    input  release_o,
    input  repeat_o
  );

  modport slave (
    input  noisy_ni,
    output pressed_o,
    output press_o,
    output release_o,
    output repeat_o
  );
endinterface

// File: rtl/key_conditioner_sync2.sv
// Two-flop synchroniser with a configurable reset level.
// Also used for slide-switch inputs.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic nReset_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;
  logic [1:0] ff_d;

  always_comb ff_d = {ff_q[0], d_i};

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) ff_q <= {2{RST_VAL}};
    else           ff_q <= ff_d;
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/key_conditioner.sv
// Debounced level plus press/release/auto-repeat strobes
// for an active-low push-button on the system clock.
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned CNT_BITS   = CNT_BITS_DEF,
  parameter bit          RPT_EN     = 1'b1,
  parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
  parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF
) (
  input  logic clk_i,
  input  logic nReset_i,
  input  logic noisy_ni,
  output logic pressed_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned HW = hold_bits(RPT_DELAY, RPT_PERIOD);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [HW-1:0] DLY = HW'(RPT_DELAY);
  localparam logic [HW-1:0] PER = HW'(RPT_PERIOD);

  logic key_n_sync;
  logic key_s;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i    (clk_i),
    .nReset_i (nReset_i),
    .d_i      (noisy_ni),
    .q_o      (key_n_sync)
  );

  assign key_s = ~key_n_sync;

  key_state_e    state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [HW-1:0] hold_inc;
  logic [HW-1:0] target;
  logic          rpt2_q, rpt2_d;
  logic          pressed_q, pressed_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;

  // hold counter restarts on each repeat; rpt2 picks period over delay
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    rpt2_d    = rpt2_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    hold_inc  = (hold_q == '1) ? hold_q : hold_q + HW'(1);
    target    = rpt2_q ? PER : DLY;
    unique case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          press_d = 1'b1;
          hold_d  = '0;
          rpt2_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (RPT_EN && hold_inc == target) begin
          repeat_d = 1'b1;
          hold_d   = '0;
          rpt2_d   = 1'b1;
        end else begin
          hold_d = hold_inc;
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
    endcase
    pressed_d = (state_d == PRESSED) ||
                (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      rpt2_q    <= 1'b0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      rpt2_q    <= rpt2_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign pressed_o = pressed_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: directed pin
// waveforms, expected strobes queued with their cycle.
module tb_key_conditioner;
  import key_pkg::*;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } ev_t;

  localparam logic [2:0] K_PRESS = 3'b100;
  localparam logic [2:0] K_REL   = 3'b010;
  localparam logic [2:0] K_RPT   = 3'b001;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  q[$];

  logic pressed0, press0, rel0, rpt0;
  int   press0_n = 0;
  int   rel0_n = 0;
  int   rpt0_n = 0;

  key_conditioner_if kif();

  key_conditioner #(
    .CNT_BITS(3), .RPT_EN(1'b1),
    .RPT_DELAY(20), .RPT_PERIOD(5)
  ) dut (
    .clk_i     (clk),
    .nReset_i  (rst_n),
    .noisy_ni  (kif.noisy_ni),
    .pressed_o (kif.pressed_o),
    .press_o   (kif.press_o),
    .release_o (kif.release_o),
    .repeat_o  (kif.repeat_o)
  );

  key_conditioner #(
    .CNT_BITS(3), .RPT_EN(1'b0),
    .RPT_DELAY(20), .RPT_PERIOD(5)
  ) dut0 (
    .clk_i     (clk),
    .nReset_i  (rst_n),
    .noisy_ni  (kif.noisy_ni),
    .pressed_o (pressed0),
    .press_o   (press0),
    .release_o (rel0),
    .repeat_o  (rpt0)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d",
               nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [2:0] k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lvl_at(input int c, input logic exp,
                        input string nm);
    goto(c);
    @(negedge clk);
    chk(nm, int'(kif.pressed_o), int'(exp));
  endtask

  function automatic int outs();
    return int'({kif.pressed_o, kif.press_o,
                 kif.release_o, kif.repeat_o});
  endfunction

  // monitor: strobes are matched against the queue head
  always @(negedge clk) begin
    logic [2:0] kn;
    ev_t e;
    kn = {kif.press_o, kif.release_o, kif.repeat_o};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk("missing_event_cyc", cyc, e.cyc);
    end
    if (kn != 3'b000) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", int'(kn), 0);
      end else begin
        e = q.pop_front();
        chk("strobe_cyc", cyc, e.cyc);
        chk("strobe_kind", int'(kn), int'(e.kind));
      end
    end
    if (press0) press0_n++;
    if (rel0)   rel0_n++;
    if (rpt0)   rpt0_n++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, p, r, b, d, f, g, h;
    rst_n = 1'b0;
    kif.noisy_ni = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;
    e0 = cyc;

    goto(e0 + 20);
    kif.noisy_ni = 1'b0;
    goto(e0 + 21);
    kif.noisy_ni = 1'b1;
    lvl_at(e0 + 50, 1'b0, "idle_level");

    e0 = cyc;
    kif.noisy_ni = 1'b0;
    p = e0 + 11;
    push(p, K_PRESS);
    push(p + 20, K_RPT);
    push(p + 25, K_RPT);
    push(p + 30, K_RPT);
    push(p + 35, K_RPT);
    lvl_at(p - 1, 1'b0, "press_pre_lvl");
    lvl_at(p, 1'b1, "press_lvl");

    r = p + 36;
    goto(r);
    kif.noisy_ni = 1'b1;
    goto(r + 3);
    kif.noisy_ni = 1'b0;
    goto(r + 4);
    kif.noisy_ni = 1'b1;
    push(r + 15, K_REL);
    lvl_at(r + 6, 1'b1, "rel_bounce_lvl");
    lvl_at(r + 14, 1'b1, "rel_pre_lvl");
    lvl_at(r + 15, 1'b0, "rel_lvl");

    b = r + 20;
    goto(b);
    kif.noisy_ni = 1'b0;
    goto(b + 4);
    kif.noisy_ni = 1'b1;
    goto(b + 6);
    kif.noisy_ni = 1'b0;
    push(b + 17, K_PRESS);
    lvl_at(b + 16, 1'b0, "bounce_pre_lvl");
    lvl_at(b + 17, 1'b1, "bounce_lvl");

    goto(b + 25);
    @(negedge clk);
    #2;
    chk("pre_reset_lvl", int'(kif.pressed_o), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pressed", outs(), 0);
    goto(b + 27);
    rst_n = 1'b1;
    d = cyc;
    push(d + 11, K_PRESS);
    lvl_at(d + 11, 1'b1, "post_rst_lvl");

    f = d + 16;
    goto(f);
    kif.noisy_ni = 1'b1;
    push(f + 11, K_REL);
    lvl_at(f + 11, 1'b0, "rel2_lvl");

    g = f + 14;
    goto(g);
    kif.noisy_ni = 1'b0;
    goto(g + 6);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_wait", outs(), 0);
    goto(g + 9);
    rst_n = 1'b1;
    h = cyc;
    push(h + 11, K_PRESS);
    lvl_at(h + 11, 1'b1, "post_rst2_lvl");
    goto(h + 13);
    kif.noisy_ni = 1'b1;
    push(h + 24, K_REL);
    lvl_at(h + 24, 1'b0, "rel3_lvl");

    goto(h + 30);
    chk("queue_drained", q.size(), 0);
    chk("rpt_en0_repeats", rpt0_n, 0);
    chk("rpt_en0_presses", press0_n, 4);
    chk("rpt_en0_releases", rel0_n, 3);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
